// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access codes,
// FSM state type and the alignment / byte-enable helpers used by the top level.
package lsu_mem_stage_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } lsuState_t;

  // Misaligned halfword/word, reserved funct3, or unsigned-size store.
  function automatic logic accessIllegal(input logic [2:0] funct3,
                                         input logic [1:0] addrLo,
                                         input logic       isWrite);
    logic bad;
    bad = 1'b0;
    case (funct3)
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = addrLo[0];
      LSU_W:   bad = (addrLo != 2'b00);
      LSU_BU:  bad = isWrite;
      LSU_HU:  bad = isWrite | addrLo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] funct3,
                                            input logic [1:0] addrLo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addrLo;
      2'b01:   be = 4'b0011 << addrLo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data alignment: picks the addressed byte/halfword lane from the bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_ext
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  funct3,
  output logic [31:0] loadData
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = rdata[{addrLo, 3'b000} +: 8];
    laneHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B:   loadData = {{24{laneByte[7]}}, laneByte};
      LSU_H:   loadData = {{16{laneHalf[15]}}, laneHalf};
      LSU_W:   loadData = rdata;
      LSU_BU:  loadData = {24'd0, laneByte};
      LSU_HU:  loadData = {16'd0, laneHalf};
      default: loadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: turns M-stage load/store strobes into a single
// outstanding req/gnt/rvalid bus access and stalls the pipeline until it ends.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  lsuState
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsuState_t        state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic             access, isWrite, illegal, timeoutHit;
  logic [31:0]      loadData, storeData;

  assign access   = MemReadM | MemWriteM;
  assign isWrite  = MemWriteM;
  assign illegal  = accessIllegal(funct3M, Mem_WrAddr[1:0], isWrite);
  assign lsuState = state;

  // waitCnt holds the number of cycles spent waiting, including the current one.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (waitCnt == CNT_LIMIT);

  lsu_load_ext uLoadExt (
    .rdata   (bus_rdata),
    .addrLo  (Mem_WrAddr[1:0]),
    .funct3  (funct3M),
    .loadData(loadData)
  );

  always_comb begin
    case (funct3M[1:0])
      2'b00:   storeData = {4{Mem_WrData[7:0]}};
      2'b01:   storeData = {2{Mem_WrData[15:0]}};
      default: storeData = Mem_WrData;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Outputs are forced low while reset is high so an aborted access releases
  // the bus and the pipeline without waiting for a clock edge.
  always_comb begin
    stateNext  = state;
    bus_req    = 1'b0;
    StallM     = 1'b0;
    misalign_o = 1'b0;
    timeout_o  = 1'b0;
    ReadData   = 32'd0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (illegal) begin
              misalign_o = 1'b1;
            end else begin
              bus_req = 1'b1;
              if (bus_gnt && !isWrite) begin
                stateNext = WAIT_RSP;
                StallM    = 1'b1;
              end else if (!bus_gnt) begin
                stateNext = WAIT_GNT;
                StallM    = 1'b1;
              end
            end
          end
        end
        WAIT_GNT: begin
          if (bus_gnt && isWrite) begin
            bus_req   = 1'b1;
            stateNext = IDLE;
          end else if (timeoutHit) begin
            timeout_o = 1'b1;
            stateNext = IDLE;
          end else begin
            bus_req = 1'b1;
            StallM  = 1'b1;
            if (bus_gnt) stateNext = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus_rvalid) begin
            ReadData  = loadData;
            stateNext = IDLE;
          end else if (timeoutHit) begin
            timeout_o = 1'b1;
            stateNext = IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    if (stateNext == IDLE || TIMEOUT_CYCLES == 0) waitCntNext = '0;
    else                                          waitCntNext = waitCnt + CNT_W'(1);
  end

  assign bus_we    = bus_req & isWrite;
  assign bus_addr  = bus_req ? {Mem_WrAddr[31:2], 2'b00} : 32'd0;
  assign bus_be    = bus_req ? byteEnable(funct3M, Mem_WrAddr[1:0]) : 4'd0;
  assign bus_wdata = (bus_req && isWrite) ? storeData : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table of single accesses plus
// hand-written sequences for wait states, timeouts and asynchronous reset.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] Mem_WrAddr, Mem_WrData;
  logic [31:0] ReadData;
  logic        StallM, misalign_o, timeout_o;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [1:0]  lsuState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .StallM(StallM), .misalign_o(misalign_o), .timeout_o(timeout_o),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .lsuState(lsuState)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we, re;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        expReq;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expStall, expMis;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM = we; MemReadM = re; funct3M = f3; Mem_WrAddr = addr; Mem_WrData = wdata;
  endtask

  task automatic clearInputs();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic we, input logic re, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic expReq,
                                 input logic [3:0] expBe, input logic [31:0] expWdata,
                                 input logic expStall, input logic expMis,
                                 input logic [31:0] expRead);
    vec_t v;
    v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.expReq = expReq; v.expBe = expBe; v.expWdata = expWdata;
    v.expStall = expStall; v.expMis = expMis; v.expRead = expRead;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    clearInputs();
    #2;
    check("rst_state", 32'(lsuState), 32'(IDLE));
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    drive(1'b0, 1'b1, LSU_W, 32'h0000_5000, 32'd0);
    #1;
    check("rst_req_gated", 32'(bus_req), 32'd0);
    check("rst_stall_gated", 32'(StallM), 32'd0);
    check("rst_addr_gated", bus_addr, 32'd0);
    clearInputs();
    #9 reset = 1'b0;
    nextCycle();

    //       we re f3      addr          wdata         rdata         req be       wdata exp     stl mis read
    addVec(1, 0, LSU_B,  32'h0000_1003, 32'h0000_00A5, 32'd0,        1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 32'd0);
    addVec(1, 0, LSU_H,  32'h0000_1002, 32'h1234_BEEF, 32'd0,        1, 4'b1100, 32'hBEEF_BEEF, 0, 0, 32'd0);
    addVec(1, 0, LSU_W,  32'h0000_1008, 32'hDEAD_BEEF, 32'd0,        1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'd0);
    addVec(1, 0, LSU_B,  32'h0000_1000, 32'h0000_007F, 32'd0,        1, 4'b0001, 32'h7F7F_7F7F, 0, 0, 32'd0);
    addVec(1, 1, LSU_W,  32'h0000_100C, 32'h0102_0304, 32'd0,        1, 4'b1111, 32'h0102_0304, 0, 0, 32'd0);
    addVec(1, 0, LSU_W,  32'h0000_3002, 32'h1111_1111, 32'd0,        0, 4'b0000, 32'd0,         0, 1, 32'd0);
    addVec(1, 0, LSU_H,  32'h0000_3001, 32'h2222_2222, 32'd0,        0, 4'b0000, 32'd0,         0, 1, 32'd0);
    addVec(1, 0, LSU_BU, 32'h0000_3000, 32'h3333_3333, 32'd0,        0, 4'b0000, 32'd0,         0, 1, 32'd0);
    addVec(0, 1, 3'b011, 32'h0000_3000, 32'd0,         32'd0,        0, 4'b0000, 32'd0,         0, 1, 32'd0);
    addVec(0, 1, LSU_H,  32'h0000_2001, 32'd0,         32'd0,        0, 4'b0000, 32'd0,         0, 1, 32'd0);
    addVec(0, 1, LSU_B,  32'h0000_2001, 32'd0,         32'h12F0_3456, 1, 4'b0010, 32'd0,        1, 0, 32'h0000_0034);
    addVec(0, 1, LSU_H,  32'h0000_2002, 32'd0,         32'h12F0_3456, 1, 4'b1100, 32'd0,        1, 0, 32'h0000_12F0);
    addVec(0, 1, LSU_HU, 32'h0000_2002, 32'd0,         32'h8000_0000, 1, 4'b1100, 32'd0,        1, 0, 32'h0000_8000);
    addVec(0, 1, LSU_B,  32'h0000_2002, 32'd0,         32'h12F0_3456, 1, 4'b0100, 32'd0,        1, 0, 32'hFFFF_FFF0);
    addVec(0, 1, LSU_W,  32'h0000_2004, 32'd0,         32'hCAFE_F00D, 1, 4'b1111, 32'd0,        1, 0, 32'hCAFE_F00D);
    addVec(0, 1, LSU_BU, 32'h0000_2003, 32'd0,         32'h9A00_0000, 1, 4'b1000, 32'd0,        1, 0, 32'h0000_009A);
    addVec(0, 1, LSU_H,  32'h0000_2000, 32'd0,         32'h0000_8001, 1, 4'b0011, 32'd0,        1, 0, 32'hFFFF_8001);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      bus_gnt = 1'b1;
      #3;
      check($sformatf("v%0d_req", i), 32'(bus_req), 32'(vecs[i].expReq));
      check($sformatf("v%0d_we", i), 32'(bus_we), 32'(vecs[i].expReq & vecs[i].we));
      check($sformatf("v%0d_addr", i), bus_addr, vecs[i].expReq ? {vecs[i].addr[31:2], 2'b00} : 32'd0);
      check($sformatf("v%0d_be", i), 32'(bus_be), 32'(vecs[i].expBe));
      check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].expWdata);
      check($sformatf("v%0d_stall", i), 32'(StallM), 32'(vecs[i].expStall));
      check($sformatf("v%0d_mis", i), 32'(misalign_o), 32'(vecs[i].expMis));
      check($sformatf("v%0d_rd0", i), ReadData, 32'd0);
      if (vecs[i].expStall) exp_q.push_back(vecs[i].expRead);
      nextCycle();
      bus_gnt = 1'b0;
      if (vecs[i].expStall) begin
        bus_rvalid = 1'b1;
        bus_rdata  = vecs[i].rdata;
        #3;
        check($sformatf("v%0d_read", i), ReadData, exp_q.pop_front());
        check($sformatf("v%0d_stall_done", i), 32'(StallM), 32'd0);
        check($sformatf("v%0d_req_rsp", i), 32'(bus_req), 32'd0);
        nextCycle();
      end
      clearInputs();
      #3;
      check($sformatf("v%0d_mis_clear", i), 32'(misalign_o), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(lsuState), 32'(IDLE));
      nextCycle();
    end

    // lb with gnt in cycle 0 and rvalid in cycle 2.
    drive(1'b0, 1'b1, LSU_B, 32'h0000_2001, 32'd0);
    bus_gnt = 1'b1;
    #3;
    check("lb_c0_stall", 32'(StallM), 32'd1);
    check("lb_c0_req", 32'(bus_req), 32'd1);
    nextCycle();
    bus_gnt = 1'b0;
    #3;
    check("lb_c1_stall", 32'(StallM), 32'd1);
    check("lb_c1_req", 32'(bus_req), 32'd0);
    check("lb_c1_state", 32'(lsuState), 32'(WAIT_RSP));
    check("lb_c1_rd", ReadData, 32'd0);
    nextCycle();
    bus_rvalid = 1'b1; bus_rdata = 32'h12F0_3456;
    #3;
    check("lb_c2_rd", ReadData, 32'h0000_0034);
    check("lb_c2_stall", 32'(StallM), 32'd0);
    nextCycle();
    clearInputs();

    // lw with gnt held off for three cycles; stray rvalid in WAIT_GNT is ignored.
    drive(1'b0, 1'b1, LSU_W, 32'h0000_3004, 32'd0);
    for (int c = 0; c < 3; c++) begin
      bus_rvalid = (c == 1);
      bus_rdata  = 32'hBAD0_BAD0;
      #3;
      check($sformatf("gd_c%0d_req", c), 32'(bus_req), 32'd1);
      check($sformatf("gd_c%0d_addr", c), bus_addr, 32'h0000_3004);
      check($sformatf("gd_c%0d_be", c), 32'(bus_be), 32'hF);
      check($sformatf("gd_c%0d_stall", c), 32'(StallM), 32'd1);
      check($sformatf("gd_c%0d_rd", c), ReadData, 32'd0);
      nextCycle();
    end
    bus_rvalid = 1'b0;
    bus_gnt = 1'b1;
    #3;
    check("gd_c3_req", 32'(bus_req), 32'd1);
    check("gd_c3_stall", 32'(StallM), 32'd1);
    nextCycle();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h55AA_33CC;
    #3;
    check("gd_c4_rd", ReadData, 32'h55AA_33CC);
    check("gd_c4_stall", 32'(StallM), 32'd0);
    check("gd_c4_tmo_loses", 32'(timeout_o), 32'd0);
    nextCycle();
    clearInputs();
    #3;
    check("gd_idle", 32'(lsuState), 32'(IDLE));
    nextCycle();

    // lw with no gnt: timeout on the 4th cycle in WAIT_GNT, then a late rvalid.
    drive(1'b0, 1'b1, LSU_W, 32'h0000_3008, 32'd0);
    #3;
    check("tg_c0_stall", 32'(StallM), 32'd1);
    nextCycle();
    for (int c = 1; c < 4; c++) begin
      #3;
      check($sformatf("tg_c%0d_tmo", c), 32'(timeout_o), 32'd0);
      check($sformatf("tg_c%0d_req", c), 32'(bus_req), 32'd1);
      check($sformatf("tg_c%0d_stall", c), 32'(StallM), 32'd1);
      nextCycle();
    end
    #3;
    check("tg_c4_tmo", 32'(timeout_o), 32'd1);
    check("tg_c4_req", 32'(bus_req), 32'd0);
    check("tg_c4_stall", 32'(StallM), 32'd0);
    check("tg_c4_rd", ReadData, 32'd0);
    nextCycle();
    clearInputs();
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #3;
    check("tg_late_tmo", 32'(timeout_o), 32'd0);
    check("tg_late_rd", ReadData, 32'd0);
    check("tg_late_stall", 32'(StallM), 32'd0);
    check("tg_late_state", 32'(lsuState), 32'(IDLE));
    nextCycle();
    #3;
    check("tg_late_state2", 32'(lsuState), 32'(IDLE));
    bus_rvalid = 1'b0;
    nextCycle();

    // lw granted at once, rvalid never arrives: timeout from WAIT_RSP.
    drive(1'b0, 1'b1, LSU_W, 32'h0000_300C, 32'd0);
    bus_gnt = 1'b1;
    nextCycle();
    bus_gnt = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #3;
      check($sformatf("tr_c%0d_stall", c), 32'(StallM), 32'd1);
      check($sformatf("tr_c%0d_tmo", c), 32'(timeout_o), 32'd0);
      nextCycle();
    end
    #3;
    check("tr_c4_tmo", 32'(timeout_o), 32'd1);
    check("tr_c4_stall", 32'(StallM), 32'd0);
    check("tr_c4_rd", ReadData, 32'd0);
    nextCycle();
    clearInputs();
    nextCycle();

    // Asynchronous reset in the middle of a WAIT_RSP cycle.
    drive(1'b0, 1'b1, LSU_W, 32'h0000_4000, 32'd0);
    bus_gnt = 1'b1;
    nextCycle();
    bus_gnt = 1'b0;
    #2;
    check("ar_pre_stall", 32'(StallM), 32'd1);
    check("ar_pre_state", 32'(lsuState), 32'(WAIT_RSP));
    reset = 1'b1;
    #1;
    check("ar_stall", 32'(StallM), 32'd0);
    check("ar_req", 32'(bus_req), 32'd0);
    check("ar_state", 32'(lsuState), 32'(IDLE));
    clearInputs();
    #3 reset = 1'b0;
    nextCycle();
    #3;
    check("ar_post_state", 32'(lsuState), 32'(IDLE));
    nextCycle();
    drive(1'b0, 1'b1, LSU_W, 32'h0000_4004, 32'd0);
    bus_gnt = 1'b1;
    #3;
    check("ar_lw_req", 32'(bus_req), 32'd1);
    check("ar_lw_addr", bus_addr, 32'h0000_4004);
    nextCycle();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
    #3;
    check("ar_lw_rd", ReadData, 32'h0BAD_F00D);
    check("ar_lw_stall", 32'(StallM), 32'd0);
    nextCycle();
    clearInputs();
    #3;
    check("ar_lw_idle", 32'(lsuState), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
